// File: rtl/qspi_flash_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : qspi_flash_sequencer                                            |
// | Brief    : walks a byte-level QSPI master through opcode, address, dummy   |
// |            and data phases; per-byte watchdog under QSPI_SEQ_TIMEOUT_EN    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module qspi_flash_sequencer #(
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_opcode,
   input  logic             req_has_addr,
   input  logic [23:0]      req_addr,
   input  logic [2:0]       req_dummy,
   input  logic [LEN_W-1:0] req_len,
   input  logic             req_write,
   input  logic             req_quad,
   input  logic [7:0]       wdata,
   input  logic             wdata_valid,
   output logic             wdata_ready,
   output logic [7:0]       rdata,
   output logic             rdata_valid,
   input  logic             rdata_ready,
   output logic             done,
   output logic             err,
   output logic             busy,
   output logic             m_start,
   output logic [7:0]       m_wr_byte,
   output logic             m_dir_rd,
   output logic             m_quad,
   output logic             m_last,
   input  logic             m_done,
   input  logic [7:0]       m_rd_byte,
   output logic             m_abort
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CMD    = 3'd1,
      S_ADDR   = 3'd2,
      S_DUMMY  = 3'd3,
      S_DATA   = 3'd4,
      S_WAIT   = 3'd5,
      S_FINISH = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   state_t           r_phase;
   state_t           w_after;
   logic [7:0]       r_opcode;
   logic [23:0]      r_addr;
   logic [1:0]       r_addr_cnt;
   logic [2:0]       r_dummy_cnt;
   logic [LEN_W-1:0] r_len_cnt;
   logic             r_write;
   logic             r_quad;
   logic [7:0]       r_rdata;
   logic             r_rdata_valid;
   logic             w_timeout;

   if (TIMEOUT_CYC < 2 || LEN_W < 1) begin : g_bad_cfg
      $error("qspi_flash_sequencer: unsupported parameter values");
   end

   assign req_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;

   // Counters are decremented at launch, so once in WAIT they already
   // describe the remaining work and pick the next phase directly.
   always_comb begin
      w_after = S_FINISH;
      if (r_addr_cnt != 2'd0)
         w_after = S_ADDR;
      else if (r_dummy_cnt != 3'd0)
         w_after = S_DUMMY;
      else if (r_len_cnt != '0)
         w_after = S_DATA;
   end

   always_comb begin
      w_state_nxt = r_state;
      m_start     = 1'b0;
      m_wr_byte   = 8'h00;
      m_dir_rd    = 1'b0;
      m_quad      = 1'b0;
      m_last      = 1'b0;
      m_abort     = 1'b0;
      wdata_ready = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid)
               w_state_nxt = S_CMD;
         end
         S_CMD: begin
            m_start     = 1'b1;
            m_wr_byte   = r_opcode;
            m_last      = (r_addr_cnt == 2'd0) && (r_dummy_cnt == 3'd0) && (r_len_cnt == '0);
            w_state_nxt = S_WAIT;
         end
         S_ADDR: begin
            m_start     = 1'b1;
            m_wr_byte   = r_addr[23:16];
            m_last      = (r_addr_cnt == 2'd1) && (r_dummy_cnt == 3'd0) && (r_len_cnt == '0);
            w_state_nxt = S_WAIT;
         end
         S_DUMMY: begin
            m_start     = 1'b1;
            m_dir_rd    = 1'b1;
            m_quad      = r_quad;
            m_last      = (r_dummy_cnt == 3'd1) && (r_len_cnt == '0);
            w_state_nxt = S_WAIT;
         end
         S_DATA: begin
            if (r_write ? wdata_valid : !r_rdata_valid) begin
               m_start     = 1'b1;
               wdata_ready = r_write;
               m_wr_byte   = r_write ? wdata : 8'h00;
               m_dir_rd    = !r_write;
               m_quad      = r_quad;
               m_last      = (r_len_cnt == LEN_W'(1));
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (m_done) begin
               w_state_nxt = w_after;
            end else if (w_timeout) begin
               m_abort     = 1'b1;
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            if (!r_rdata_valid) begin
               done        = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_phase       <= S_IDLE;
         r_opcode      <= 8'h00;
         r_addr        <= 24'h000000;
         r_addr_cnt    <= 2'd0;
         r_dummy_cnt   <= 3'd0;
         r_len_cnt     <= '0;
         r_write       <= 1'b0;
         r_quad        <= 1'b0;
         r_rdata       <= 8'h00;
         r_rdata_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_opcode    <= req_opcode;
                  r_addr      <= req_addr;
                  r_addr_cnt  <= req_has_addr ? 2'd3 : 2'd0;
                  r_dummy_cnt <= req_dummy;
                  r_len_cnt   <= req_len;
                  r_write     <= req_write;
                  r_quad      <= req_quad;
               end
            end
            S_ADDR: begin
               r_addr     <= {r_addr[15:0], 8'h00};
               r_addr_cnt <= r_addr_cnt - 2'd1;
            end
            S_DUMMY: r_dummy_cnt <= r_dummy_cnt - 3'd1;
            S_DATA: begin
               if (m_start)
                  r_len_cnt <= r_len_cnt - LEN_W'(1);
            end
            default: ;
         endcase
         if (m_start)
            r_phase <= r_state;
         if (m_abort) begin
            r_rdata_valid <= 1'b0;
         end else if (r_state == S_WAIT && m_done && r_phase == S_DATA && !r_write) begin
            r_rdata       <= m_rd_byte;
            r_rdata_valid <= 1'b1;
         end else if (r_rdata_valid && rdata_ready) begin
            r_rdata_valid <= 1'b0;
         end
      end
   end

`ifdef QSPI_SEQ_TIMEOUT_EN
   localparam int c_wdog_w = $clog2(TIMEOUT_CYC);

   logic [c_wdog_w-1:0] r_wdog;
   logic                r_err;

   // Restarts on every launch; the first WAIT cycle sees zero.
   always_ff @(posedge sys_clk) begin
      if (rst || r_state != S_WAIT)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + c_wdog_w'(1);
   end

   always_ff @(posedge sys_clk) begin
      if (rst || r_state == S_IDLE)
         r_err <= 1'b0;
      else if (m_abort)
         r_err <= 1'b1;
   end

   assign w_timeout = (r_wdog == c_wdog_w'(TIMEOUT_CYC - 1));
   assign err       = done & r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

endmodule
`default_nettype wire
